fp_addsub_sequencer: RTL and testbench

- Parametrised multi-cycle control sequencer for the floating-point add/subtract datapath.
- Accepts a start handshake and steps through alignment, add/subtract, normalisation and rounding, driving all datapath mux selects, shifter and exponent enables.
- Raises Done with Zero/Overflow/Underflow status at the end of each operation.
- Generalises the single-step controller:
  - alignment runs as a multi-cycle shift of at most SHIFTSTEP bits per cycle;
  - effective subtraction is supported;
  - the handshake is explicit (Busy/Done);
  - a post-round renormalisation pass is included;
  - exception flags are reported.

---
 rtl/fp_ctrl_pkg.sv | 17 +
 rtl/fp_align_step.sv | 33 +++
 rtl/fp_addsub_sequencer.sv | 145 ++++++++++++++
 tb/tb_fp_addsub_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_ctrl_pkg.sv
// Shared types and helpers for the floating-point add/subtract control sequencer.
package fp_ctrl_pkg;

  localparam int DEF_EXPBITS      = 8;
  localparam int DEF_MANTISSABITS = 23;

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_CHECK, S_RENORM, S_DONE
  } state_t;

  // Shifting right past the whole datapath is equivalent to a full clear,
  // so the alignment count saturates at the datapath width.
  function automatic int align_count(input int diff, input int limit);
    return (diff < limit) ? diff : limit;
  endfunction

endpackage

// File: rtl/fp_align_step.sv
// Multi-cycle alignment counter: emits at most SHIFTSTEP bits of right shift per cycle.
module fp_align_step #(
  parameter int SHIFTSTEP = 8,
  parameter int SAW       = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [SAW-1:0] load_val,
  input  logic           step,
  output logic [SAW-1:0] shift_amt,
  output logic           shift_en,
  output logic           last
);

  localparam logic [SAW-1:0] STEP = SAW'(SHIFTSTEP);

  logic [SAW-1:0] rem;
  logic [SAW-1:0] chunk;

  assign chunk     = (rem < STEP) ? rem : STEP;
  assign shift_amt = step ? chunk : '0;
  assign shift_en  = step && (rem != '0);
  // Remaining count reaches zero after this cycle's chunk.
  assign last      = (rem <= STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rem <= '0;
    else if (load) rem <= load_val;
    else if (step) rem <= rem - chunk;
  end

endmodule

// File: rtl/fp_addsub_sequencer.sv
// Control FSM for the FP add/subtract datapath: align, add/sub, normalise, round, renormalise.
// Leading-one and exponent are sampled while in ADD, i.e. from the adder output before it is registered.
module fp_addsub_sequencer
  import fp_ctrl_pkg::*;
#(
  parameter int  EXPBITS      = DEF_EXPBITS,
  parameter int  MANTISSABITS = DEF_MANTISSABITS,
  parameter int  SHIFTSTEP    = 8,
  localparam int NBITS        = $clog2(MANTISSABITS+2),
  localparam int SAW          = $clog2(MANTISSABITS+3)
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Go,
  input  logic                    Sub,
  input  logic                    ExpSet,
  input  logic [EXPBITS-1:0]      ExpDiff,
  input  logic [EXPBITS-1:0]      ExpResult,
  input  logic                    FFOValid,
  input  logic [NBITS-1:0]        FFOIndex,
  input  logic [MANTISSABITS+1:0] Out,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Zero,
  output logic                    Overflow,
  output logic                    Underflow,
  output logic                    SelExpMux,
  output logic                    SelSRMux,
  output logic                    ShiftRightEnable,
  output logic [SAW-1:0]          ShiftRightAmount,
  output logic                    AddEn,
  output logic                    SubEn,
  output logic                    SREn,
  output logic                    SLEn,
  output logic                    NoShift,
  output logic [NBITS-1:0]        ShiftAmount,
  output logic                    IncrEn,
  output logic                    DecrEn,
  output logic                    RoundEn,
  output logic                    SelExpMuxR,
  output logic                    SelManMuxR
);

  localparam logic [NBITS-1:0] IDX_TOP = NBITS'(MANTISSABITS+1);
  localparam logic [NBITS-1:0] IDX_NRM = NBITS'(MANTISSABITS);

  state_t           state, next_state;
  logic             sub_q, es_q, zero_q, uf_q, ovf_q;
  logic [NBITS-1:0] idx_q;
  logic             accept, align_last;
  logic             out_unused;

  assign accept     = (state == S_IDLE) && Go;
  assign out_unused = ^Out[MANTISSABITS:0];

  fp_align_step #(.SHIFTSTEP(SHIFTSTEP), .SAW(SAW)) u_align (
    .clk       (Clock),
    .rst       (Reset),
    .load      (accept),
    .load_val  (SAW'(align_count(int'(ExpDiff), MANTISSABITS+2))),
    .step      (state == S_ALIGN),
    .shift_amt (ShiftRightAmount),
    .shift_en  (ShiftRightEnable),
    .last      (align_last)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state  <= S_IDLE;
      sub_q  <= 1'b0;
      es_q   <= 1'b0;
      zero_q <= 1'b0;
      uf_q   <= 1'b0;
      ovf_q  <= 1'b0;
      idx_q  <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        sub_q  <= Sub;
        es_q   <= ExpSet;
        zero_q <= 1'b0;
        uf_q   <= 1'b0;
        ovf_q  <= 1'b0;
      end
      if (state == S_ADD) begin
        zero_q <= !FFOValid;
        idx_q  <= FFOIndex;
        // Left shift by MANTISSABITS-idx would take the exponent to zero or below.
        uf_q   <= FFOValid && (FFOIndex < IDX_NRM) &&
                  (int'(ExpResult) <= MANTISSABITS - int'(FFOIndex));
      end
      if (next_state == S_DONE) ovf_q <= &ExpResult;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:   if (Go) next_state = S_ALIGN;
      S_ALIGN:  if (align_last) next_state = S_ADD;
      S_ADD:    next_state = S_NORM;
      S_NORM:   next_state = zero_q ? S_DONE : S_ROUND;
      S_ROUND:  next_state = S_CHECK;
      S_CHECK:  next_state = Out[MANTISSABITS+1] ? S_RENORM : S_DONE;
      S_RENORM: next_state = S_DONE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    Busy        = (state != S_IDLE);
    Done        = (state == S_DONE);
    Zero        = Done && zero_q;
    Overflow    = Done && ovf_q;
    Underflow   = Done && uf_q;
    SelExpMux   = Busy && es_q;
    SelSRMux    = Busy && es_q;
    AddEn       = (state == S_ADD) && !sub_q;
    SubEn       = (state == S_ADD) && sub_q;
    RoundEn     = (state == S_ROUND);
    SelExpMuxR  = (state == S_RENORM);
    SelManMuxR  = (state == S_RENORM);
    SREn        = (state == S_RENORM);
    IncrEn      = (state == S_RENORM);
    SLEn        = 1'b0;
    DecrEn      = 1'b0;
    NoShift     = 1'b0;
    ShiftAmount = '0;
    if (state == S_NORM && !zero_q) begin
      if (idx_q == IDX_TOP) begin
        SREn        = 1'b1;
        IncrEn      = 1'b1;
        ShiftAmount = NBITS'(1);
      end else if (idx_q == IDX_NRM) begin
        NoShift     = 1'b1;
      end else if (idx_q < IDX_NRM) begin
        SLEn        = 1'b1;
        DecrEn      = 1'b1;
        ShiftAmount = IDX_NRM - idx_q;
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_sequencer.sv
// Bench for fp_addsub_sequencer: directed vector table, hand sequences, random ops vs. cycle model.
module tb_fp_addsub_sequencer;

  localparam int EB  = 8;
  localparam int MB  = 23;
  localparam int SS  = 8;
  localparam int NB  = $clog2(MB+2);
  localparam int SAW = $clog2(MB+3);

  typedef struct packed {
    logic busy, done, zero, ovf, uf, selexp, selsr, sre;
    logic [SAW-1:0] sra;
    logic add, sub, sren, slen, nosh;
    logic [NB-1:0] shamt;
    logic incr, decr, rnd, selexpr, selmanr;
  } ctl_t;

  typedef struct {
    bit sub, es;
    int diff;
    bit ffov;
    int idx, er;
    bit carry;
    int done_c;
    bit [2:0] fl;   // {zero, overflow, underflow} expected at Done
  } vec_t;

  logic clk = 1'b0;
  logic rst, Go, Sub, ExpSet, FFOValid;
  logic [EB-1:0] ExpDiff, ExpResult;
  logic [NB-1:0] FFOIndex;
  logic [MB+1:0] Out;
  logic Busy, Done, Zero, Overflow, Underflow, SelExpMux, SelSRMux, ShiftRightEnable;
  logic [SAW-1:0] ShiftRightAmount;
  logic AddEn, SubEn, SREn, SLEn, NoShift, IncrEn, DecrEn, RoundEn, SelExpMuxR, SelManMuxR;
  logic [NB-1:0] ShiftAmount;

  ctl_t act;
  ctl_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[15];

  always #5 clk = ~clk;

  fp_addsub_sequencer #(.EXPBITS(EB), .MANTISSABITS(MB), .SHIFTSTEP(SS)) dut (
    .Clock(clk), .Reset(rst), .Go(Go), .Sub(Sub), .ExpSet(ExpSet), .ExpDiff(ExpDiff),
    .ExpResult(ExpResult), .FFOValid(FFOValid), .FFOIndex(FFOIndex), .Out(Out),
    .Busy(Busy), .Done(Done), .Zero(Zero), .Overflow(Overflow), .Underflow(Underflow),
    .SelExpMux(SelExpMux), .SelSRMux(SelSRMux), .ShiftRightEnable(ShiftRightEnable),
    .ShiftRightAmount(ShiftRightAmount), .AddEn(AddEn), .SubEn(SubEn), .SREn(SREn),
    .SLEn(SLEn), .NoShift(NoShift), .ShiftAmount(ShiftAmount), .IncrEn(IncrEn),
    .DecrEn(DecrEn), .RoundEn(RoundEn), .SelExpMuxR(SelExpMuxR), .SelManMuxR(SelManMuxR)
  );

  assign act = {Busy, Done, Zero, Overflow, Underflow, SelExpMux, SelSRMux, ShiftRightEnable,
                ShiftRightAmount, AddEn, SubEn, SREn, SLEn, NoShift, ShiftAmount,
                IncrEn, DecrEn, RoundEn, SelExpMuxR, SelManMuxR};

  function automatic ctl_t busy_base(input bit es);
    ctl_t c = '0;
    c.busy = 1'b1; c.selexp = es; c.selsr = es;
    return c;
  endfunction

  // Expected per-cycle control trace for one operation, cycle 1 = first cycle after acceptance.
  task automatic build_exp(input bit sub, input bit es, input int diff, input bit ffov,
                           input int idx, input int er, input bit carry, output int done_c);
    ctl_t c;
    int rem, amt;
    exp_q.delete();
    rem = (diff > MB+2) ? MB+2 : diff;
    do begin
      c = busy_base(es);
      amt = (rem < SS) ? rem : SS;
      c.sre = (rem != 0);
      c.sra = SAW'(amt);
      rem -= amt;
      exp_q.push_back(c);
    end while (rem != 0);
    c = busy_base(es); c.add = !sub; c.sub = sub; exp_q.push_back(c);
    c = busy_base(es);
    if (ffov) begin
      if (idx == MB+1) begin c.sren = 1'b1; c.incr = 1'b1; c.shamt = NB'(1); end
      else if (idx == MB) c.nosh = 1'b1;
      else begin c.slen = 1'b1; c.decr = 1'b1; c.shamt = NB'(MB - idx); end
    end
    exp_q.push_back(c);
    if (ffov) begin
      c = busy_base(es); c.rnd = 1'b1; exp_q.push_back(c);
      c = busy_base(es); exp_q.push_back(c);
      if (carry) begin
        c = busy_base(es); c.sren = 1'b1; c.incr = 1'b1; c.selexpr = 1'b1; c.selmanr = 1'b1;
        exp_q.push_back(c);
      end
    end
    c = busy_base(es);
    c.done = 1'b1;
    c.zero = !ffov;
    c.ovf  = (er == 255);
    c.uf   = ffov && (idx < MB) && (er <= MB - idx);
    exp_q.push_back(c);
    done_c = exp_q.size();
    exp_q.push_back('0);
    exp_q.push_back('0);
  endtask

  task automatic run_op(input string nm, input vec_t v, input bit go_busy);
    int dc, seen;
    bit [2:0] fl_seen;
    build_exp(v.sub, v.es, v.diff, v.ffov, v.idx, v.er, v.carry, dc);
    @(negedge clk);
    Sub = v.sub; ExpSet = v.es; ExpDiff = EB'(v.diff); FFOValid = v.ffov;
    FFOIndex = NB'(v.idx); ExpResult = EB'(v.er);
    Out = {(v.carry ? 2'b10 : 2'b01), MB'($urandom)};
    Go = 1'b1;
    seen = -1;
    fl_seen = '0;
    for (int n = 1; n <= exp_q.size(); n++) begin
      @(negedge clk);
      checks++;
      if (act !== exp_q[n-1]) begin
        errors++;
        $display("FAIL %s cycle %0d: controls got %h want %h", nm, n, act, exp_q[n-1]);
      end
      if (Done === 1'b1 && seen < 0) begin seen = n; fl_seen = {Zero, Overflow, Underflow}; end
      if (go_busy) begin
        Go = (n <= dc);
        Sub = ~v.sub; ExpSet = ~v.es; ExpDiff = EB'($urandom);
      end else Go = 1'b0;
    end
    Go = 1'b0;
    if (v.done_c >= 0) begin
      checks++;
      if (seen != v.done_c || fl_seen != v.fl) begin
        errors++;
        $display("FAIL %s done: cycle %0d flags %b, want cycle %0d flags %b",
                 nm, seen, fl_seen, v.done_c, v.fl);
      end
    end
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; Go = 1'b0; Sub = 1'b0; ExpSet = 1'b0; ExpDiff = '0; ExpResult = '0;
    FFOValid = 1'b0; FFOIndex = '0; Out = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (act !== '0) begin errors++; $display("FAIL reset_state: got %h want 0", act); end
    rst = 1'b0;

    //        sub   es    diff ffov  idx er   carry done flags
    vecs[0]  = '{1'b0, 1'b1, 85,  1'b1, 23, 100, 1'b0, 9, 3'b000};
    vecs[1]  = '{1'b0, 1'b0, 0,   1'b1, 24, 100, 1'b0, 6, 3'b000};
    vecs[2]  = '{1'b1, 1'b1, 3,   1'b1, 20, 10,  1'b0, 6, 3'b000};
    vecs[3]  = '{1'b1, 1'b1, 3,   1'b1, 20, 2,   1'b0, 6, 3'b001};
    vecs[4]  = '{1'b0, 1'b0, 0,   1'b0, 0,  50,  1'b0, 4, 3'b100};
    vecs[5]  = '{1'b0, 1'b1, 0,   1'b1, 23, 60,  1'b1, 7, 3'b000};
    vecs[6]  = '{1'b0, 1'b0, 0,   1'b1, 23, 255, 1'b0, 6, 3'b010};
    vecs[7]  = '{1'b0, 1'b1, 8,   1'b1, 23, 40,  1'b0, 6, 3'b000};
    vecs[8]  = '{1'b1, 1'b0, 9,   1'b1, 23, 40,  1'b0, 7, 3'b000};
    vecs[9]  = '{1'b0, 1'b1, 25,  1'b1, 24, 40,  1'b0, 9, 3'b000};
    vecs[10] = '{1'b1, 1'b0, 255, 1'b1, 23, 40,  1'b0, 9, 3'b000};
    vecs[11] = '{1'b1, 1'b1, 2,   1'b1, 20, 3,   1'b0, 6, 3'b001};
    vecs[12] = '{1'b1, 1'b0, 16,  1'b1, 0,  30,  1'b1, 8, 3'b000};
    vecs[13] = '{1'b1, 1'b1, 20,  1'b0, 7,  50,  1'b1, 6, 3'b100};
    vecs[14] = '{1'b0, 1'b0, 1,   1'b1, 24, 255, 1'b1, 7, 3'b010};
    for (int i = 0; i < 15; i++) run_op($sformatf("vec%0d", i), vecs[i], 1'b0);

    // Go held high (with changing operands) through the whole op and DONE
    run_op("go_while_busy", '{1'b0, 1'b1, 20, 1'b1, 22, 80, 1'b0, 8, 3'b000}, 1'b1);

    // Reset asserted mid-ALIGN must clear outputs without a clock edge
    @(negedge clk);
    ExpDiff = EB'(85); ExpSet = 1'b1; Sub = 1'b0; Go = 1'b1;
    @(negedge clk);
    Go = 1'b0;
    checks++;
    if (act.sre !== 1'b1) begin errors++; $display("FAIL rst_pre_align: sre got %b want 1", act.sre); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (act !== '0) begin errors++; $display("FAIL rst_async: got %h want 0", act); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (act !== '0) begin errors++; $display("FAIL rst_idle: got %h want 0", act); end
    run_op("after_reset", '{1'b1, 1'b0, 0, 1'b1, 24, 100, 1'b0, 6, 3'b000}, 1'b0);

    for (int i = 0; i < 40; i++) begin
      v.sub   = 1'($urandom);
      v.es    = 1'($urandom);
      v.diff  = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 40));
      v.ffov  = ($urandom_range(0, 7) != 0);
      v.idx   = int'($urandom_range(0, 24));
      v.er    = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 30)) : int'($urandom_range(0, 255));
      v.carry = 1'($urandom);
      v.done_c = -1;
      v.fl    = '0;
      run_op($sformatf("rand%0d", i), v, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
